vec_mem_seq: RTL and testbench

VEC_MEM_SEQ -- requirements
Module: vec_mem_seq

---
 rtl/vec_mem_seq_pkg.sv | 22 ++
 rtl/vec_mem_seq.sv | 117 +++++++++++
 tb/tb_vec_mem_seq.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_seq_pkg.sv
// Shared vector-unit definitions: lane geometry and the memory sequencer state encoding.
// Used by the vector register file, the vector ALU and vec_mem_seq.
package vec_mem_seq_pkg;

  localparam int VEC_LANES  = 5;
  localparam int VEC_STRIDE = 4;
  localparam int LANE_W     = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_FIN  = 2'd2
  } vec_mem_state_t;

  // Byte address of a lane; wraps modulo 2^32.
  function automatic logic [31:0] lane_addr(input logic [31:0]       base,
                                            input logic [LANE_W-1:0] lane,
                                            input int                stride);
    return base + (32'(stride) * 32'(lane));
  endfunction

endpackage

// File: rtl/vec_mem_seq.sv
// Vector load/store sequencer: moves one 32-bit lane per cycle between the
// vector register file and the scalar data memory port.
//
// state | meaning
// IDLE  | waiting for start; misaligned start pulses err next cycle
// XFER  | one lane per cycle, lane 0..LANES-1 ascending
// FIN   | done pulse; ld_we pulse for loads
module vec_mem_seq
  import vec_mem_seq_pkg::*;
#(
  parameter int LANES  = VEC_LANES,
  parameter int STRIDE = VEC_STRIDE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        is_store,
  input  logic [31:0] base_addr,
  input  logic [31:0] st_data_0,
  input  logic [31:0] st_data_1,
  input  logic [31:0] st_data_2,
  input  logic [31:0] st_data_3,
  input  logic [31:0] st_data_4,
  input  logic [31:0] ReadData,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  output logic [31:0] ld_data_0,
  output logic [31:0] ld_data_1,
  output logic [31:0] ld_data_2,
  output logic [31:0] ld_data_3,
  output logic [31:0] ld_data_4,
  output logic        ld_we,
  output logic        stall,
  output logic        done,
  output logic        err
);

  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

  vec_mem_state_t    state;
  logic [LANE_W-1:0] lane_q;
  logic              is_store_q;
  logic [31:0]       base_q;
  logic [31:0]       st_buf [LANES];
  logic [31:0]       ld_q   [LANES];
  logic              err_q;
  logic              aligned;

  assign aligned = (base_addr[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lane_q     <= '0;
      is_store_q <= 1'b0;
      base_q     <= '0;
      err_q      <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        st_buf[i] <= '0;
        ld_q[i]   <= '0;
      end
    end else begin
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (aligned) begin
              is_store_q <= is_store;
              base_q     <= base_addr;
              lane_q     <= '0;
              st_buf[0]  <= st_data_0;
              st_buf[1]  <= st_data_1;
              st_buf[2]  <= st_data_2;
              st_buf[3]  <= st_data_3;
              st_buf[4]  <= st_data_4;
              state      <= ST_XFER;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        ST_XFER: begin
          if (!is_store_q) ld_q[lane_q] <= ReadData;
          if (lane_q == LAST_LANE) state <= ST_FIN;
          else                     lane_q <= lane_q + 1'b1;
        end
        ST_FIN:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // mem_we is masked by reset so an aborted store issues no write in the reset cycle.
  always_comb begin
    mem_addr = '0;
    mem_wd   = '0;
    mem_we   = 1'b0;
    if (state == ST_XFER) begin
      mem_addr = lane_addr(base_q, lane_q, STRIDE);
      mem_we   = is_store_q & ~reset;
      if (is_store_q) mem_wd = st_buf[lane_q];
    end
  end

  assign stall = (state != ST_IDLE) | (start & aligned);
  assign done  = (state == ST_FIN);
  assign ld_we = (state == ST_FIN) & ~is_store_q;
  assign err   = err_q;

  assign ld_data_0 = ld_q[0];
  assign ld_data_1 = ld_q[1];
  assign ld_data_2 = ld_q[2];
  assign ld_data_3 = ld_q[3];
  assign ld_data_4 = ld_q[4];

endmodule

// File: tb/tb_vec_mem_seq.sv
// Directed bench for vec_mem_seq: vector table of loads/stores plus
// hand-written reset-abort, busy-start and load-hold sequences.
module tb_vec_mem_seq;

  typedef struct packed {
    logic            is_store;
    logic [31:0]     base;
    logic [4:0][31:0] d;
    logic            exp_err;
    logic [4:0][31:0] a;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, is_store;
  logic [31:0] base_addr;
  logic [31:0] st [5];
  logic [31:0] ReadData;
  logic [31:0] mem_addr, mem_wd;
  logic        mem_we, ld_we, stall, done, err;
  logic [31:0] ld0, ld1, ld2, ld3, ld4;

  logic [31:0] ld_img [256];
  logic [31:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];

  int total = 0;
  int bad   = 0;

  vec_t vecs [6];

  always #5 clk = ~clk;

  vec_mem_seq dut (
    .clk(clk), .reset(reset), .start(start), .is_store(is_store),
    .base_addr(base_addr),
    .st_data_0(st[0]), .st_data_1(st[1]), .st_data_2(st[2]),
    .st_data_3(st[3]), .st_data_4(st[4]),
    .ReadData(ReadData),
    .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_we(mem_we),
    .ld_data_0(ld0), .ld_data_1(ld1), .ld_data_2(ld2),
    .ld_data_3(ld3), .ld_data_4(ld4),
    .ld_we(ld_we), .stall(stall), .done(done), .err(err)
  );

  assign ReadData = ld_img[mem_addr[9:2]];

  always @(posedge clk) begin
    if (mem_we) begin
      wr_addr_q.push_back(mem_addr);
      wr_data_q.push_back(mem_wd);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ldv(input int i);
    case (i)
      0: return ld0;
      1: return ld1;
      2: return ld2;
      3: return ld3;
      default: return ld4;
    endcase
  endfunction

  function automatic vec_t mk(input logic st_op, input logic [31:0] b,
                              input logic [31:0] d0, input logic [31:0] d1,
                              input logic [31:0] d2, input logic [31:0] d3,
                              input logic [31:0] d4, input logic e,
                              input logic [31:0] a0, input logic [31:0] a1,
                              input logic [31:0] a2, input logic [31:0] a3,
                              input logic [31:0] a4);
    vec_t v;
    v.is_store = st_op;
    v.base     = b;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3; v.d[4] = d4;
    v.exp_err  = e;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = a3; v.a[4] = a4;
    return v;
  endfunction

  // Entered at posedge+1 with the DUT idle.
  task automatic run_vec(input vec_t v, input string tag);
    int w0;
    w0 = wr_addr_q.size();
    if (!v.is_store && !v.exp_err)
      for (int i = 0; i < 5; i++) ld_img[v.a[i][9:2]] = v.d[i];
    start     = 1'b1;
    is_store  = v.is_store;
    base_addr = v.base;
    for (int i = 0; i < 5; i++) st[i] = v.is_store ? v.d[i] : (32'hBAD0_0000 + 32'(i));
    #1;
    chk1({tag, " stall_at_start"}, stall, ~v.exp_err);
    step();
    start = 1'b0;
    #1;
    if (v.exp_err) begin
      chk1({tag, " err"}, err, 1'b1);
      chk1({tag, " err_stall"}, stall, 1'b0);
      chk1({tag, " err_we"}, mem_we, 1'b0);
      step();
      chk1({tag, " err_clear"}, err, 1'b0);
      chk({tag, " err_writes"}, wr_addr_q.size() - w0, 32'd0);
    end else begin
      for (int i = 0; i < 5; i++) begin
        chk({tag, $sformatf(" addr%0d", i)}, mem_addr, v.a[i]);
        chk1({tag, $sformatf(" we%0d", i)}, mem_we, v.is_store);
        if (v.is_store) chk({tag, $sformatf(" wd%0d", i)}, mem_wd, v.d[i]);
        chk1({tag, $sformatf(" stall%0d", i)}, stall, 1'b1);
        chk1({tag, $sformatf(" early_done%0d", i)}, done, 1'b0);
        step();
      end
      chk1({tag, " done"}, done, 1'b1);
      chk1({tag, " ld_we"}, ld_we, ~v.is_store);
      chk1({tag, " fin_we"}, mem_we, 1'b0);
      chk({tag, " fin_addr"}, mem_addr, 32'h0);
      if (!v.is_store)
        for (int k = 0; k < 5; k++) chk({tag, $sformatf(" ld%0d", k)}, ldv(k), v.d[k]);
      step();
      chk1({tag, " idle_done"}, done, 1'b0);
      chk1({tag, " idle_stall"}, stall, 1'b0);
      chk1({tag, " idle_ld_we"}, ld_we, 1'b0);
      if (v.is_store) begin
        chk({tag, " nwrites"}, wr_addr_q.size() - w0, 32'd5);
        if (wr_addr_q.size() - w0 == 5)
          for (int k = 0; k < 5; k++) begin
            chk({tag, $sformatf(" log_addr%0d", k)}, wr_addr_q[w0 + k], v.a[k]);
            chk({tag, $sformatf(" log_data%0d", k)}, wr_data_q[w0 + k], v.d[k]);
          end
      end else begin
        chk({tag, " load_writes"}, wr_addr_q.size() - w0, 32'd0);
      end
    end
  endtask

  initial begin
    int w0;
    int n_done;
    for (int i = 0; i < 256; i++) ld_img[i] = 32'h0;

    vecs[0] = mk(1'b1, 32'h100, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 1'b0,
                 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110);
    vecs[1] = mk(1'b0, 32'h200, 32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 1'b0,
                 32'h200, 32'h204, 32'h208, 32'h20C, 32'h210);
    vecs[2] = mk(1'b1, 32'h102, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 1'b1,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    vecs[3] = mk(1'b1, 32'hFFFF_FFF8, 32'h21, 32'h22, 32'h23, 32'h24, 32'h25, 1'b0,
                 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0, 32'h4, 32'h8);
    vecs[4] = mk(1'b0, 32'h40, 32'hDEAD_BEEF, 32'h1234_5678, 32'h0, 32'hFFFF_FFFF,
                 32'h5A5A_5A5A, 1'b0, 32'h40, 32'h44, 32'h48, 32'h4C, 32'h50);
    vecs[5] = mk(1'b0, 32'h203, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b1,
                 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

    reset = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = 32'h0;
    for (int i = 0; i < 5; i++) st[i] = 32'h0;
    step();
    step();
    chk1("rst mem_we", mem_we, 1'b0);
    chk1("rst done", done, 1'b0);
    chk1("rst err", err, 1'b0);
    chk1("rst ld_we", ld_we, 1'b0);
    chk1("rst stall", stall, 1'b0);
    chk("rst mem_addr", mem_addr, 32'h0);
    chk("rst ld_data_0", ld0, 32'h0);
    reset = 1'b0;
    step();

    for (int v = 0; v < 6; v++) begin
      run_vec(vecs[v], $sformatf("vec%0d", v));
      step();
    end

    // ld_data holds the last load (vec4) across the rejected misaligned load.
    chk("hold ld_data_0", ld0, 32'hDEAD_BEEF);
    chk("hold ld_data_4", ld4, 32'h5A5A_5A5A);

    // Reset during XFER of a store: only lanes 0 and 1 reach memory.
    w0 = wr_addr_q.size();
    n_done = 0;
    start = 1'b1; is_store = 1'b1; base_addr = 32'h300;
    for (int i = 0; i < 5; i++) st[i] = 32'h11 + 32'(i);
    step();                 // N+1
    start = 1'b0;
    step();                 // N+2
    step();                 // N+3
    reset = 1'b1;
    #1;
    chk1("abort we_in_reset", mem_we, 1'b0);
    step();                 // N+4
    reset = 1'b0;
    #1;
    chk("abort addr", mem_addr, 32'h0);
    chk1("abort stall", stall, 1'b0);
    chk1("abort we", mem_we, 1'b0);
    chk("abort ld_cleared", ld0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      if (done) n_done++;
      step();
    end
    chk("abort done_count", 32'(n_done), 32'd0);
    chk("abort nwrites", wr_addr_q.size() - w0, 32'd2);
    if (wr_addr_q.size() - w0 == 2) begin
      chk("abort w0_addr", wr_addr_q[w0], 32'h300);
      chk("abort w1_addr", wr_addr_q[w0 + 1], 32'h304);
    end

    // Start held through a whole transfer: second transfer begins only after IDLE at N+7.
    w0 = wr_addr_q.size();
    start = 1'b1; is_store = 1'b1; base_addr = 32'h400;
    for (int i = 0; i < 5; i++) st[i] = 32'h31 + 32'(i);
    for (int c = 1; c <= 7; c++) begin
      step();
      if (c == 6) chk1("busy done_n6", done, 1'b1);
      if (c < 6) chk("busy addr", mem_addr, 32'h400 + 32'(4 * (c - 1)));
    end
    #1;
    chk1("busy stall_n7", stall, 1'b1);
    chk1("busy we_n7", mem_we, 1'b0);
    chk("busy writes_n7", wr_addr_q.size() - w0, 32'd5);
    step();                 // N+8: second transfer lane 0
    start = 1'b0;
    #1;
    chk1("busy second_we", mem_we, 1'b1);
    chk("busy second_addr", mem_addr, 32'h400);
    for (int i = 0; i < 7; i++) step();
    chk("busy total_writes", wr_addr_q.size() - w0, 32'd10);
    chk1("busy final_stall", stall, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
